// File: rtl/cv32e40px_rf_wb_arbiter.sv
// Round-robin write-back arbiter for register file port B. Registers the
// granted write; pair writes go out natively or as two back-to-back singles.
module cv32e40px_rf_wb_arbiter #(
   parameter int unsigned N_REQ       = 3,
   parameter int unsigned ADDR_WIDTH  = 6,
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned X_DUALWRITE = 0
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic [N_REQ-1:0]                       req_valid_i,
   output logic [N_REQ-1:0]                       req_ready_o,
   input  logic [N_REQ-1:0][ADDR_WIDTH-1:0]       req_addr_i,
   input  logic [N_REQ-1:0]                       req_dual_i,
   input  logic [N_REQ-1:0][1:0][DATA_WIDTH-1:0]  req_data_i,
   output logic [ADDR_WIDTH-1:0]                  waddr_b_o,
   output logic [1:0][DATA_WIDTH-1:0]             wdata_b_o,
   output logic [1:0]                             we_b_o,
   output logic                                   busy_o,
   output logic                                   dual_err_o
);

   localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic {IDLE, SPLIT} state_e;

   state_e                   state_q, state_d;
   logic [IDX_W-1:0]         rr_q, gnt_idx, rr_next;
   logic                     gnt_vld, hs;
   logic                     sel_dual, sel_even_dual, do_split;
   logic [ADDR_WIDTH-1:0]    sel_addr, split_addr_q;
   logic [1:0][DATA_WIDTH-1:0] sel_data;
   logic [DATA_WIDTH-1:0]    split_data_q;
   int unsigned              cand;

   // First valid requester scanning upward from rr_q, wrapping at N_REQ.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      cand    = 0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         cand = 32'(rr_q) + k;
         if (cand >= N_REQ) cand = cand - N_REQ;
         if (!gnt_vld && req_valid_i[IDX_W'(cand)]) begin
            gnt_vld = 1'b1;
            gnt_idx = IDX_W'(cand);
         end
      end
   end

   assign hs            = gnt_vld && (state_q == IDLE) && !rst;
   assign sel_addr      = req_addr_i[gnt_idx];
   assign sel_data      = req_data_i[gnt_idx];
   assign sel_dual      = req_dual_i[gnt_idx];
   assign sel_even_dual = sel_dual && !sel_addr[0];
   assign do_split      = sel_even_dual && (X_DUALWRITE == 0);
   assign rr_next       = (32'(gnt_idx) == N_REQ - 1) ? '0 : gnt_idx + 1'b1;

   always_comb begin
      req_ready_o = '0;
      if (hs) req_ready_o[gnt_idx] = 1'b1;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (hs && do_split) state_d = SPLIT;
         SPLIT:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         rr_q         <= '0;
         we_b_o       <= 2'b00;
         waddr_b_o    <= '0;
         wdata_b_o    <= '0;
         dual_err_o   <= 1'b0;
         split_addr_q <= '0;
         split_data_q <= '0;
      end else begin
         state_q    <= state_d;
         we_b_o     <= 2'b00;
         dual_err_o <= 1'b0;
         if (state_q == SPLIT) begin
            waddr_b_o    <= split_addr_q;
            wdata_b_o[0] <= split_data_q;
            we_b_o       <= 2'b01;
         end else if (hs) begin
            rr_q         <= rr_next;
            waddr_b_o    <= sel_addr;
            wdata_b_o[0] <= sel_data[0];
            // Odd-based pairs degrade to a single write of data[0].
            dual_err_o   <= sel_dual && sel_addr[0];
            if (sel_even_dual && (X_DUALWRITE != 0)) begin
               wdata_b_o[1] <= sel_data[1];
               we_b_o       <= 2'b11;
            end else begin
               we_b_o       <= 2'b01;
            end
            if (do_split) begin
               split_addr_q <= sel_addr | ADDR_WIDTH'(1);
               split_data_q <= sel_data[1];
            end
         end
      end
   end

   assign busy_o = (we_b_o != 2'b00) || (state_q == SPLIT);

endmodule

// File: tb/tb_cv32e40px_rf_wb_arbiter.sv
// Directed bench: dut0 splits pair writes, dut1 writes pairs natively.
module tb_cv32e40px_rf_wb_arbiter;

   logic                  clk, rst;
   logic [2:0]            valid, dual;
   logic [2:0][5:0]       addr;
   logic [2:0][1:0][31:0] data;

   logic [2:0]       rdy0, rdy1;
   logic [5:0]       wa0, wa1;
   logic [1:0][31:0] wd0, wd1;
   logic [1:0]       we0, we1;
   logic             busy0, busy1, derr0, derr1;

   int n_tests = 0;
   int n_fail  = 0;

   cv32e40px_rf_wb_arbiter #(.N_REQ(3), .ADDR_WIDTH(6), .DATA_WIDTH(32), .X_DUALWRITE(0)) dut0 (
      .clk(clk), .rst(rst), .req_valid_i(valid), .req_ready_o(rdy0), .req_addr_i(addr),
      .req_dual_i(dual), .req_data_i(data), .waddr_b_o(wa0), .wdata_b_o(wd0), .we_b_o(we0),
      .busy_o(busy0), .dual_err_o(derr0));

   cv32e40px_rf_wb_arbiter #(.N_REQ(3), .ADDR_WIDTH(6), .DATA_WIDTH(32), .X_DUALWRITE(1)) dut1 (
      .clk(clk), .rst(rst), .req_valid_i(valid), .req_ready_o(rdy1), .req_addr_i(addr),
      .req_dual_i(dual), .req_data_i(data), .waddr_b_o(wa1), .wdata_b_o(wd1), .we_b_o(we1),
      .busy_o(busy1), .dual_err_o(derr1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  valid;
      logic [2:0]  ready;
      logic [1:0]  we;
      logic [5:0]  waddr;
      logic [31:0] wd;
      logic        busy;
   } vec_t;

   vec_t tv[10];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst   = 1'b1;
      valid = '0;
      dual  = '0;
      tick();
      rst   = 1'b0;
   endtask

   initial begin
      // round-robin over singles; rr_q after each grant noted by the grant order
      tv[0] = '{3'b111, 3'b001, 2'b01, 6'd1, 32'hA, 1'b1};
      tv[1] = '{3'b111, 3'b010, 2'b01, 6'd2, 32'hB, 1'b1};
      tv[2] = '{3'b111, 3'b100, 2'b01, 6'd3, 32'hC, 1'b1};
      tv[3] = '{3'b111, 3'b001, 2'b01, 6'd1, 32'hA, 1'b1};
      tv[4] = '{3'b000, 3'b000, 2'b00, 6'd1, 32'hA, 1'b0};
      tv[5] = '{3'b100, 3'b100, 2'b01, 6'd3, 32'hC, 1'b1};
      tv[6] = '{3'b011, 3'b001, 2'b01, 6'd1, 32'hA, 1'b1};
      tv[7] = '{3'b110, 3'b010, 2'b01, 6'd2, 32'hB, 1'b1};
      tv[8] = '{3'b101, 3'b100, 2'b01, 6'd3, 32'hC, 1'b1};
      tv[9] = '{3'b011, 3'b001, 2'b01, 6'd1, 32'hA, 1'b1};

      rst   = 1'b1;
      valid = 3'b111;
      dual  = '0;
      addr  = '0;
      data  = '0;
      addr[0] = 6'd1;  data[0][0] = 32'hA;
      addr[1] = 6'd2;  data[1][0] = 32'hB;
      addr[2] = 6'd3;  data[2][0] = 32'hC;

      // reset held two cycles with all valids high
      for (int c = 0; c < 2; c++) begin
         tick();
         chk("rst_ready0", 64'(rdy0), 64'd0);
         chk("rst_ready1", 64'(rdy1), 64'd0);
         chk("rst_we0",    64'(we0),  64'd0);
         chk("rst_busy0",  64'(busy0), 64'd0);
         chk("rst_waddr0", 64'(wa0),  64'd0);
      end
      rst = 1'b0;

      for (int i = 0; i < 10; i++) begin
         valid = tv[i].valid;
         #1;
         chk($sformatf("rr_ready[%0d]", i), 64'(rdy0), 64'(tv[i].ready));
         tick();
         chk($sformatf("rr_we[%0d]", i),    64'(we0),   64'(tv[i].we));
         chk($sformatf("rr_waddr[%0d]", i), 64'(wa0),   64'(tv[i].waddr));
         chk($sformatf("rr_wdata[%0d]", i), 64'(wd0[0]), 64'(tv[i].wd));
         chk($sformatf("rr_busy[%0d]", i),  64'(busy0), 64'(tv[i].busy));
      end
      valid = '0;

      // native pair write on dut1, then a back-to-back single
      do_reset();
      addr[1] = 6'd4;
      dual    = 3'b010;
      data[1][0] = 32'h11;
      data[1][1] = 32'h22;
      valid   = 3'b010;
      #1;
      chk("nat_ready", 64'(rdy1), 64'b010);
      tick();
      chk("nat_waddr", 64'(wa1), 64'd4);
      chk("nat_wdata", 64'(wd1), 64'h0000_0022_0000_0011);
      chk("nat_we",    64'(we1), 64'b11);
      chk("nat_derr",  64'(derr1), 64'd0);
      valid = 3'b011;
      #1;
      chk("nat_b2b_ready", 64'(rdy1), 64'b001);
      tick();
      chk("nat_b2b_we",    64'(we1), 64'b01);
      chk("nat_b2b_waddr", 64'(wa1), 64'd1);
      chk("nat_b2b_wdata", 64'(wd1[0]), 64'hA);
      valid = '0;

      // split pair write on dut0 with req2 waiting
      do_reset();
      dual    = 3'b001;
      addr[0] = 6'h26;
      data[0][0] = 32'hCAFE;
      data[0][1] = 32'hBEEF;
      valid   = 3'b101;
      #1;
      chk("spl_ready_n", 64'(rdy0), 64'b001);
      tick();
      valid = 3'b100;
      chk("spl_waddr1", 64'(wa0), 64'h26);
      chk("spl_wdata1", 64'(wd0[0]), 64'hCAFE);
      chk("spl_we1",    64'(we0), 64'b01);
      chk("spl_busy1",  64'(busy0), 64'd1);
      #1;
      chk("spl_ready_n1", 64'(rdy0), 64'b000);
      tick();
      chk("spl_waddr2", 64'(wa0), 64'h27);
      chk("spl_wdata2", 64'(wd0[0]), 64'hBEEF);
      chk("spl_we2",    64'(we0), 64'b01);
      chk("spl_ready_n2", 64'(rdy0), 64'b100);
      tick();
      chk("spl_waddr3", 64'(wa0), 64'd3);
      chk("spl_wdata3", 64'(wd0[0]), 64'hC);
      chk("spl_we3",    64'(we0), 64'b01);
      valid = '0;

      // odd dual base: single write plus one-cycle error pulse
      dual    = 3'b001;
      addr[0] = 6'd5;
      data[0][0] = 32'h44;
      data[0][1] = 32'h55;
      valid   = 3'b001;
      #1;
      chk("odd_ready", 64'(rdy0), 64'b001);
      tick();
      valid = '0;
      chk("odd_waddr", 64'(wa0), 64'd5);
      chk("odd_wdata", 64'(wd0[0]), 64'h44);
      chk("odd_we",    64'(we0), 64'b01);
      chk("odd_derr",  64'(derr0), 64'd1);
      tick();
      chk("odd_derr_off", 64'(derr0), 64'd0);
      chk("odd_we_off",   64'(we0), 64'b00);
      chk("odd_busy_off", 64'(busy0), 64'd0);

      // reset asserted during the SPLIT cycle drops the second half
      addr[0] = 6'h26;
      valid   = 3'b001;
      #1;
      chk("mid_ready", 64'(rdy0), 64'b001);
      tick();
      valid = '0;
      chk("mid_we1",  64'(we0), 64'b01);
      chk("mid_busy", 64'(busy0), 64'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst_we",    64'(we0), 64'b00);
      chk("mid_rst_waddr", 64'(wa0), 64'd0);
      chk("mid_rst_busy",  64'(busy0), 64'd0);
      tick();
      chk("mid_no2nd_we",   64'(we0), 64'b00);
      chk("mid_no2nd_busy", 64'(busy0), 64'd0);
      valid = 3'b001;
      #1;
      chk("mid_idle_ready", 64'(rdy0), 64'b001);
      tick();
      valid = '0;
      chk("mid_new_waddr", 64'(wa0), 64'h26);
      chk("mid_new_we",    64'(we0), 64'b01);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
